// File: rtl/input_port_vc_sched.sv
// First-stage switch-allocation scheduler for one router input port.
// Round-robin VC pick per packet, wormhole-locked until the tail flit is granted.
module input_port_vc_sched #(
  parameter int VC_NUM        = 4,
  parameter int VC_NUM_IDX_W  = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
  parameter int OUTPORT_NUM   = 5,
  parameter int OUTPORT_IDX_W = $clog2(OUTPORT_NUM)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [VC_NUM-1:0]                 vc_head_v_i,
  input  logic [VC_NUM*OUTPORT_IDX_W-1:0]   vc_head_outport_i,
  input  logic [VC_NUM-1:0]                 vc_head_is_tail_i,
  input  logic [VC_NUM-1:0]                 vc_credit_ok_i,
  output logic                              sa_req_v_o,
  output logic [OUTPORT_IDX_W-1:0]          sa_req_outport_o,
  output logic [VC_NUM_IDX_W-1:0]           sa_req_vc_o,
  input  logic                              sa_gnt_i,
  output logic [VC_NUM-1:0]                 vc_pop_o,
  output logic                              locked_o
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                     state_q, state_d;
  logic [VC_NUM_IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [VC_NUM_IDX_W-1:0]    lock_vc_q, lock_vc_d;
  logic [OUTPORT_IDX_W-1:0]   lock_outport_q, lock_outport_d;

  logic [VC_NUM-1:0]          elig;
  logic [OUTPORT_IDX_W-1:0]   head_outport [VC_NUM];
  logic                       found;
  logic [VC_NUM_IDX_W-1:0]    sel;
  logic                       req_v;
  logic [VC_NUM_IDX_W-1:0]    req_vc;
  logic [OUTPORT_IDX_W-1:0]   req_outport;
  logic [VC_NUM-1:0]          pop;

  assign elig = vc_head_v_i & vc_credit_ok_i;

  genvar gi;
  generate
    for (gi = 0; gi < VC_NUM; gi++) begin : g_unpack
      assign head_outport[gi] = vc_head_outport_i[gi*OUTPORT_IDX_W +: OUTPORT_IDX_W];
    end
  endgenerate

  function automatic logic [VC_NUM_IDX_W-1:0] vc_incr(input logic [VC_NUM_IDX_W-1:0] v);
    if (v == VC_NUM_IDX_W'(VC_NUM - 1)) return '0;
    return v + 1'b1;
  endfunction

  // Wrap-around scan starting at rr_ptr; first eligible VC wins.
  always_comb begin
    int tmp;
    logic [VC_NUM_IDX_W-1:0] cand;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < VC_NUM; k++) begin
      tmp = int'(rr_ptr_q) + k;
      if (tmp >= VC_NUM) tmp = tmp - VC_NUM;
      cand = VC_NUM_IDX_W'(tmp);
      if (!found && elig[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    lock_vc_d      = lock_vc_q;
    lock_outport_d = lock_outport_q;
    req_v          = 1'b0;
    req_vc         = '0;
    req_outport    = '0;
    pop            = '0;

    if (state_q == IDLE) begin
      if (found) begin
        req_v       = 1'b1;
        req_vc      = sel;
        req_outport = head_outport[sel];
      end
    end else begin
      // Body flits carry no route, so the head's outport is replayed.
      req_v       = elig[lock_vc_q];
      req_vc      = lock_vc_q;
      req_outport = lock_outport_q;
    end

    if (sa_gnt_i && req_v) begin
      pop[req_vc] = 1'b1;
      if (vc_head_is_tail_i[req_vc]) begin
        state_d  = IDLE;
        rr_ptr_d = vc_incr(req_vc);
      end else if (state_q == IDLE) begin
        state_d        = LOCKED;
        lock_vc_d      = sel;
        lock_outport_d = head_outport[sel];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      lock_vc_q      <= '0;
      lock_outport_q <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      lock_vc_q      <= lock_vc_d;
      lock_outport_q <= lock_outport_d;
    end
  end

  // Outputs are forced quiet while reset is held, regardless of inputs.
  assign sa_req_v_o       = req_v & ~rst;
  assign sa_req_vc_o      = rst ? '0 : req_vc;
  assign sa_req_outport_o = rst ? '0 : req_outport;
  assign vc_pop_o         = rst ? '0 : pop;
  assign locked_o         = (state_q == LOCKED) & ~rst;

endmodule

// File: tb/tb_input_port_vc_sched.sv
// Scoreboard bench for input_port_vc_sched: each driven cycle pushes its
// expected response, which is popped and compared before the next clock edge.
module tb_input_port_vc_sched;

  localparam int VC  = 4;
  localparam int VCW = 2;
  localparam int OPW = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [VC-1:0]    vc_head_v = '0;
  logic [VC*OPW-1:0] vc_head_outport = '0;
  logic [VC-1:0]    vc_head_is_tail = '0;
  logic [VC-1:0]    vc_credit_ok = '0;
  logic             sa_gnt = 1'b0;
  logic             sa_req_v;
  logic [OPW-1:0]   sa_req_outport;
  logic [VCW-1:0]   sa_req_vc;
  logic [VC-1:0]    vc_pop;
  logic             locked;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic           req_v;
    logic [VCW-1:0] vc;
    logic [OPW-1:0] op;
    logic [VC-1:0]  pop;
    logic           locked;
    string          tag;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  input_port_vc_sched dut (
    .clk               (clk),
    .rst               (rst),
    .vc_head_v_i       (vc_head_v),
    .vc_head_outport_i (vc_head_outport),
    .vc_head_is_tail_i (vc_head_is_tail),
    .vc_credit_ok_i    (vc_credit_ok),
    .sa_req_v_o        (sa_req_v),
    .sa_req_outport_o  (sa_req_outport),
    .sa_req_vc_o       (sa_req_vc),
    .sa_gnt_i          (sa_gnt),
    .vc_pop_o          (vc_pop),
    .locked_o          (locked)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VC*OPW-1:0] ops(input int o0, input int o1, input int o2, input int o3);
    return {OPW'(o3), OPW'(o2), OPW'(o1), OPW'(o0)};
  endfunction

  task automatic push_exp(input logic ev, input logic [VCW-1:0] evc, input logic [OPW-1:0] eop,
                          input logic [VC-1:0] epop, input logic elk, input string tag);
    exp_t e;
    e.req_v = ev; e.vc = evc; e.op = eop; e.pop = epop; e.locked = elk; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic compare_front();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb_q.pop_front();
    check({e.tag, ".req_v"},   32'(sa_req_v),       32'(e.req_v));
    check({e.tag, ".vc"},      32'(sa_req_vc),      32'(e.vc));
    check({e.tag, ".outport"}, 32'(sa_req_outport), 32'(e.op));
    check({e.tag, ".pop"},     32'(vc_pop),         32'(e.pop));
    check({e.tag, ".locked"},  32'(locked),         32'(e.locked));
    $display("txn %-14s req_v=%0d vc=%0d op=%0d pop=%b locked=%0d", e.tag,
             sa_req_v, sa_req_vc, sa_req_outport, vc_pop, locked);
  endtask

  // Drive one cycle (just after posedge), check at negedge, advance past next posedge.
  task automatic step(input logic [VC-1:0] vh, input logic [VC-1:0] tl, input logic [VC-1:0] cr,
                      input logic [VC*OPW-1:0] op, input logic g,
                      input logic ev, input int evc, input int eop, input logic [VC-1:0] epop,
                      input logic elk, input string tag);
    vc_head_v = vh; vc_head_is_tail = tl; vc_credit_ok = cr; vc_head_outport = op; sa_gnt = g;
    push_exp(ev, VCW'(evc), OPW'(eop), epop, elk, tag);
    @(negedge clk);
    compare_front();
    @(posedge clk);
    #1;
  endtask

  initial begin
    @(posedge clk); #1;
    // Reset with idle inputs, then with every VC eligible: outputs stay quiet.
    step(4'b0000, 4'b0000, 4'b0000, ops(0,0,0,0), 1'b0, 0, 0, 0, 4'b0000, 0, "rst_idle");
    step(4'b1111, 4'b1111, 4'b1111, ops(1,2,3,4), 1'b1, 0, 0, 0, 4'b0000, 0, "rst_held");
    rst = 1'b0;

    // Round-robin over single-flit packets.
    step(4'b1111, 4'b1111, 4'b1111, ops(1,2,3,4), 1'b1, 1, 0, 1, 4'b0001, 0, "rr0");
    step(4'b1111, 4'b1111, 4'b1111, ops(1,2,3,4), 1'b1, 1, 1, 2, 4'b0010, 0, "rr1");
    step(4'b1111, 4'b1111, 4'b1111, ops(1,2,3,4), 1'b1, 1, 2, 3, 4'b0100, 0, "rr2");
    step(4'b1111, 4'b1111, 4'b1111, ops(1,2,3,4), 1'b1, 1, 3, 4, 4'b1000, 0, "rr3");
    step(4'b1111, 4'b1111, 4'b1111, ops(1,2,3,4), 1'b1, 1, 0, 1, 4'b0001, 0, "rr4");

    // 3-flit packet on VC1 to outport 3 while VC2 waits; body flits carry route 0.
    step(4'b0110, 4'b0000, 4'b1111, ops(0,3,4,0), 1'b1, 1, 1, 3, 4'b0010, 0, "pkt_head");
    step(4'b0110, 4'b0000, 4'b1111, ops(0,0,4,0), 1'b1, 1, 1, 3, 4'b0010, 1, "pkt_body");
    step(4'b0110, 4'b0110, 4'b1111, ops(0,0,4,0), 1'b1, 1, 1, 3, 4'b0010, 1, "pkt_tail");
    step(4'b0100, 4'b0100, 4'b1111, ops(0,0,4,0), 1'b1, 1, 2, 4, 4'b0100, 0, "pkt_next_vc2");

    // Credit stall while locked on VC0; VC3 eligible but ignored.
    step(4'b0001, 4'b0000, 4'b1111, ops(2,0,0,1), 1'b1, 1, 0, 2, 4'b0001, 0, "stall_head");
    for (int i = 0; i < 4; i++)
      step(4'b1001, 4'b1000, 4'b1110, ops(0,0,0,1), 1'b1, 0, 0, 2, 4'b0000, 1, $sformatf("stall%0d", i));
    step(4'b1001, 4'b1001, 4'b1111, ops(0,0,0,1), 1'b1, 1, 0, 2, 4'b0001, 1, "stall_resume");
    step(4'b1000, 4'b1000, 4'b1111, ops(0,0,0,1), 1'b1, 1, 3, 1, 4'b1000, 0, "stall_vc3");

    // Withheld grant with rr_ptr=3 and only VC1 eligible (wrap-around).
    step(4'b0100, 4'b1111, 4'b1111, ops(0,3,2,0), 1'b1, 1, 2, 2, 4'b0100, 0, "set_rr3");
    step(4'b0010, 4'b1111, 4'b1111, ops(0,3,2,0), 1'b0, 1, 1, 3, 4'b0000, 0, "hold0");
    step(4'b0010, 4'b1111, 4'b1111, ops(0,3,2,0), 1'b0, 1, 1, 3, 4'b0000, 0, "hold1");
    step(4'b0010, 4'b1111, 4'b1111, ops(0,3,2,0), 1'b1, 1, 1, 3, 4'b0010, 0, "hold_gnt");
    step(4'b1111, 4'b1111, 4'b1111, ops(1,2,3,4), 1'b1, 1, 2, 3, 4'b0100, 0, "rr_after_wrap");

    // Grant without a request is ignored.
    step(4'b0000, 4'b1111, 4'b1111, ops(1,2,3,4), 1'b1, 0, 0, 0, 4'b0000, 0, "gnt_no_req");
    step(4'b1111, 4'b1111, 4'b1111, ops(1,2,3,4), 1'b1, 1, 3, 4, 4'b1000, 0, "rr_unmoved");
    step(4'b0001, 4'b1111, 4'b1111, ops(1,2,3,4), 1'b1, 1, 0, 1, 4'b0001, 0, "set_rr1");

    // Lock on VC2, then assert reset between clock edges.
    step(4'b0100, 4'b0000, 4'b1111, ops(1,0,4,0), 1'b1, 1, 2, 4, 4'b0100, 0, "lk2_head");
    step(4'b0100, 4'b0000, 4'b1111, ops(1,0,0,0), 1'b0, 1, 2, 4, 4'b0000, 1, "lk2_body");
    vc_head_v = 4'b0101; vc_head_is_tail = 4'b0101; vc_head_outport = ops(1,0,4,0); sa_gnt = 1'b0;
    #2;
    rst = 1'b1;
    push_exp(1'b0, '0, '0, 4'b0000, 1'b0, "async_rst");
    @(negedge clk);
    compare_front();
    @(posedge clk); #1;
    rst = 1'b0;
    step(4'b0101, 4'b0101, 4'b1111, ops(1,0,4,0), 1'b1, 1, 0, 1, 4'b0001, 0, "post_rst");

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
